bf16_seq_multiplier: RTL and testbench
======================================

// Module: bf16_seq_multiplier
// PURPOSE
//   Iterative bfloat16 multiplier: the producer stage of the fused multiply-add datapath.
//   Its product feeds the bfloat16 adder's A/B operand port.
//   Takes operands over a valid/ready handshake and computes the 8x8 significand product
//   by shift-add, one bit per cycle. Normalises, truncates and presents a 16-bit bfloat16
//   result with overflow/underflow flags.
// PARAMETERS
//   BIAS     127    exponent bias (fixed for bfloat16; exposed for bench override only)
//   MAN_W    7      stored mantissa width; hidden bit makes significand MAN_W+1
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in   16  operand A {sign, exp[7:0], man[6:0]}
//   b          in   16  operand B, same format
//   out_valid  out  1   product/ov/uf valid
//   out_ready  in   1   consumer accepts result
//   product    out  16  bfloat16 result
//   ov         out  1   exponent overflow (result saturated to signed infinity)
//   uf         out  1   exponent underflow (result flushed to signed zero)
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - state=IDLE, in_ready=1, out_valid=0, product=16'h0000, ov=0, uf=0.
//     - Counter and all datapath registers cleared.
//   - Accept: on the edge where in_valid&&in_ready.
//     - Latch sign=a[15]^b[15], sig_a={|a[14:7],a[6:0]} and likewise sig_b.
//     - Latch exp_sum = a[14:7]+b[14:7]-BIAS as 10-bit signed.
//     - Latch special-case class.
//   - FSM IDLE->MULT->NORM->DONE->IDLE.
//     - MULT: 8 cycles; cnt 0..7. Each cycle: if sig_b[cnt] then acc+=sig_a<<cnt (16-bit acc).
//     - NORM: 1 cycle.
//       - If acc[15]: man=acc[14:8], exp_sum+=1; else man=acc[13:7].
//       - Truncation, no rounding.
//     - DONE: out_valid=1; product/ov/uf held stable until out_ready. Then IDLE, in_ready=1 next cycle.
//   - Latency: out_valid rises exactly 10 cycles after the accept edge, for every operand class.
//     Minimum issue interval is 11 cycles.
//   - in_ready=0 in MULT/NORM/DONE. in_valid outside IDLE is ignored. a/b are not re-sampled.
//   - Denormals: exp==0 is treated as zero (flush-to-zero on input).
//   - Special cases (resolved in NORM, override arithmetic; ov=uf=0 unless stated):
//     - NaN in (exp==255, man!=0), or inf*zero -> 16'h7FC0.
//     - inf*finite-nonzero -> {sign,8'hFF,7'h0}.
//     - zero*finite -> {sign,15'h0}.
//   - Arithmetic boundaries:
//     - Final exp_sum >= 255 -> {sign,8'hFF,7'h0}, ov=1.
//     - Final exp_sum <= 0 -> {sign,15'h0}, uf=1.
//   - Reset mid-operation returns to IDLE immediately. In-flight result is discarded; no out_valid pulse.
// STRUCTURE
//   - Package bf16_pkg holds:
//     - field-width localparams: EXP_W=8, MAN_W=7.
//     - BIAS.
//     - constants QNAN=16'h7FC0, POS_INF=16'h7F80, and the state enum encoding.
//     - Both the adder and this block import it.
//   - One sub-module: bf16_shift_add_core.
//     - 8x8 iterative multiplier with start/busy/done and the cnt/acc registers.
//     - Top level owns handshake, exponent path, special cases and packing.
// TESTING
//   1. a=3FC0 (1.5), b=3FC0 -> product=4010 (2.25), ov=0, uf=0, out_valid 10 cycles after accept.
//   2. a=C000 (-2), b=4040 (3) -> product=C0C0 (-6).
//   3. a=7F00, b=4000 -> product=7F80, ov=1. Also a=0080, b=0080 -> product=0000, uf=1.
//   4. Specials:
//      - a=7F80, b=0000 -> 7FC0.
//      - a=FF80, b=3F80 -> FF80.
//      - a=8000, b=4040 -> 8000.
//      - Latency still 10 cycles.
//   5. Backpressure: out_ready=0 for 5 cycles after out_valid.
//      - product/ov/uf stable, in_ready=0.
//      - A new in_valid during the stall is not accepted.
//      - Result 1.0*1.0=3F80 is then delivered.
//   6. rst_n pulsed low during MULT (cycle 4) -> outputs return to reset values asynchronously, no out_valid.
//      Next op 1.0*2.0 (3F80*4000) -> 4000.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bfloat16 field widths, constants and state encodings for the FMA datapath.
// Imported by both the multiplier and the adder.
package bf16_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] POS_INF = 16'h7F80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_NORM,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CL_NUM,
    CL_ZERO,
    CL_INF,
    CL_NAN
  } cls_t;

  // Operand-pair class; denormals (exp==0) count as zero.
  function automatic cls_t classify(input logic [15:0] a, input logic [15:0] b);
    logic a_max, b_max, a_zero, b_zero, a_nan, b_nan;
    a_max  = &a[14:7];
    b_max  = &b[14:7];
    a_zero = ~|a[14:7];
    b_zero = ~|b[14:7];
    a_nan  = a_max && |a[6:0];
    b_nan  = b_max && |b[6:0];
    if (a_nan || b_nan || (a_max && b_zero) || (b_max && a_zero)) return CL_NAN;
    if (a_max || b_max)   return CL_INF;
    if (a_zero || b_zero) return CL_ZERO;
    return CL_NUM;
  endfunction
endpackage

// File: rtl/bf16_shift_add_core.sv
// Iterative unsigned SIG_W x SIG_W multiplier, one multiplier bit per cycle.
// Operands are captured on start; done marks the cycle of the final accumulate.
module bf16_shift_add_core #(
  parameter int SIG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SIG_W-1:0]     sig_a,
  input  logic [SIG_W-1:0]     sig_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*SIG_W-1:0]   acc
);
  localparam int CNT_W = $clog2(SIG_W);

  logic [SIG_W-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(SIG_W-1));
  assign done = busy && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      acc  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      a_q  <= sig_a;
      b_q  <= sig_b;
      cnt  <= '0;
      acc  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (b_q[cnt]) acc <= acc + ({{SIG_W{1'b0}}, a_q} << cnt);
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/bf16_seq_multiplier.sv
// Iterative bfloat16 multiplier: handshake, exponent path, special cases and packing
// around the shift-add significand core. Truncating, flush-to-zero on input.
module bf16_seq_multiplier #(
  parameter int BIAS  = bf16_pkg::BIAS,
  parameter int MAN_W = bf16_pkg::MAN_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ov,
  output logic        uf
);
  import bf16_pkg::*;

  localparam int SIG_W = MAN_W + 1;
  localparam int EW    = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  state_t state_q, state_d;
  cls_t   cls_q;
  logic   sign_q, start_q, accept;
  logic   [SIG_W-1:0]   sig_a_q, sig_b_q;
  logic   signed [EW-1:0] exp_q, exp_fin;
  logic   [2*SIG_W-1:0] acc;
  logic   core_busy, core_done;
  logic   [MAN_W-1:0] man;
  logic   [15:0] res_d;
  logic   ov_d, uf_d;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_MULT;
      ST_MULT: if (core_done) state_d = ST_NORM;
      ST_NORM:                state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // The core loads one cycle after accept so the result lands exactly 10 cycles out.
  bf16_shift_add_core #(.SIG_W(SIG_W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_q),
    .sig_a (sig_a_q),
    .sig_b (sig_b_q),
    .busy  (core_busy),
    .done  (core_done),
    .acc   (acc)
  );

  // Normalise: the product of two [1,2) significands lies in [1,4).
  assign exp_fin = exp_q + EW'(acc[2*SIG_W-1]);
  assign man     = acc[2*SIG_W-1] ? acc[2*SIG_W-2 -: MAN_W] : acc[2*SIG_W-3 -: MAN_W];

  always_comb begin
    res_d = {sign_q, exp_fin[EXP_W-1:0], man};
    ov_d  = 1'b0;
    uf_d  = 1'b0;
    case (cls_q)
      CL_NAN:  res_d = QNAN;
      CL_INF:  res_d = {sign_q, POS_INF[14:0]};
      CL_ZERO: res_d = {sign_q, 15'h0};
      default: begin
        if (exp_fin >= EXP_SAT) begin
          res_d = {sign_q, POS_INF[14:0]};
          ov_d  = 1'b1;
        end else if (exp_fin <= EXP_ZERO) begin
          res_d = {sign_q, 15'h0};
          uf_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      sign_q  <= 1'b0;
      sig_a_q <= '0;
      sig_b_q <= '0;
      exp_q   <= '0;
      cls_q   <= CL_NUM;
      product <= '0;
      ov      <= 1'b0;
      uf      <= 1'b0;
    end else begin
      start_q <= accept;
      if (accept) begin
        sign_q  <= a[15] ^ b[15];
        sig_a_q <= {|a[14:7], a[MAN_W-1:0]};
        sig_b_q <= {|b[14:7], b[MAN_W-1:0]};
        exp_q   <= EW'(a[14:7]) + EW'(b[14:7]) - EW'(BIAS);
        cls_q   <= classify(a, b);
      end
      if (state_q == ST_NORM) begin
        product <= res_d;
        ov      <= ov_d;
        uf      <= uf_d;
      end
    end
  end

  // Truncated low product bits and the core's busy flag have no consumer here.
  logic unused_bits;
  assign unused_bits = core_busy ^ (^acc[MAN_W-1:0]);
endmodule

// File: tb/tb_bf16_seq_multiplier.sv
// Self-checking bench for bf16_seq_multiplier: directed spec cases plus random
// operands compared against an arithmetic bfloat16 reference model.
module tb_bf16_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        ov, uf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bf16_seq_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .ov(ov), .uf(uf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: bfloat16 multiply from field values with integer arithmetic.
  task automatic model(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] p, output logic o, output logic u);
    int ex, ey, mx, my, e, prod, m;
    logic s, xnan, ynan, xinf, yinf, xz, yz;
    ex = int'(x[14:7]); ey = int'(y[14:7]);
    mx = int'(x[6:0]);  my = int'(y[6:0]);
    s  = x[15] ^ y[15];
    xnan = (ex == 255) && (mx != 0); ynan = (ey == 255) && (my != 0);
    xinf = (ex == 255) && (mx == 0); yinf = (ey == 255) && (my == 0);
    xz = (ex == 0); yz = (ey == 0);
    o = 1'b0; u = 1'b0;
    if (xnan || ynan || (xinf && yz) || (yinf && xz)) p = 16'h7FC0;
    else if (xinf || yinf) p = {s, 15'h7F80};
    else if (xz || yz)     p = {s, 15'h0};
    else begin
      prod = (128 + mx) * (128 + my);
      e = ex + ey - 127;
      if (prod >= 32768) begin e = e + 1; m = (prod / 256) % 128; end
      else m = (prod / 128) % 128;
      if (e >= 255)    begin p = {s, 15'h7F80}; o = 1'b1; end
      else if (e <= 0) begin p = {s, 15'h0};    u = 1'b1; end
      else p = {s, 8'(e), 7'(m)};
    end
  endtask

  // Issue one op, check latency and result, hold out_ready low for `stall` cycles.
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input int stall);
    logic [15:0] ep; logic eo, eu; int lat;
    model(x, y, ep, eo, eu);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd10);
    chk({tag, ".prod"}, 32'(product), 32'(ep));
    chk({tag, ".flags"}, {30'b0, ov, uf}, {30'b0, eo, eu});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      a = 16'h4000; b = 16'h4000; in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".stall"}, {13'b0, out_valid, in_ready, ov, product},
          {13'b0, 1'b1, 1'b0, eo, ep});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".ret"}, {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [15:0] ra, rb;
    int seen;
    #12;
    chk("reset", {13'b0, in_ready, out_valid, ov, product, uf}, {13'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    do_op("mul1p5",  16'h3FC0, 16'h3FC0, 0);
    do_op("neg6",    16'hC000, 16'h4040, 0);
    do_op("ovf",     16'h7F00, 16'h4000, 0);
    do_op("udf",     16'h0080, 16'h0080, 0);
    do_op("infzero", 16'h7F80, 16'h0000, 0);
    do_op("ninf",    16'hFF80, 16'h3F80, 0);
    do_op("nzero",   16'h8000, 16'h4040, 0);
    do_op("nan",     16'h7FC1, 16'h3F80, 0);
    do_op("stall",   16'h3F80, 16'h3F80, 5);

    // Reset pulse mid-MULT.
    @(negedge clk);
    a = 16'h3FC0; b = 16'h4040; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid", {13'b0, in_ready, out_valid, ov, product, uf}, {13'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("rst_noval", 32'(seen), 32'd0);
    do_op("post_rst", 16'h3F80, 16'h4000, 0);

    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) begin
        ra = 16'($urandom); rb = 16'($urandom);
      end else begin
        ra = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom)};
      end
      do_op($sformatf("rnd%0d", i), ra, rb, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
